// File: rtl/fpga_reset_request_pkg.sv
// Shared types for the reset-request aggregator: FSM state encoding and
// the bit positions of the sticky reset-cause register.
package fpga_reset_request_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam int CAUSE_POR = 0;
    localparam int CAUSE_PLL = 1;
    localparam int CAUSE_EXT = 2;
    localparam int CAUSE_SW  = 3;

endpackage

// File: rtl/fpga_sync_filter.sv
// N-stage synchronizer followed by a stable-count filter with independent
// rise/fall thresholds. A zero threshold passes that edge through without delay.
module fpga_sync_filter #(
    parameter int STAGES      = 3,
    parameter int RISE_CYCLES = 16,
    parameter int FALL_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int MAX_TH = (RISE_CYCLES > FALL_CYCLES) ? RISE_CYCLES : FALL_CYCLES;
    localparam int CNT_W  = (MAX_TH < 1) ? 1 : $clog2(MAX_TH + 1);

    logic [STAGES-1:0] sync_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              filt_r;
    logic              synced_s;
    logic              diff_s;
    int                th_s;

    assign synced_s = sync_r[STAGES-1];

    // Threshold for the pending edge and the (possibly bypassed) filtered output.
    always_comb begin
        th_s   = filt_r ? FALL_CYCLES : RISE_CYCLES;
        diff_s = synced_s ^ filt_r;
        if (diff_s && (th_s == 0)) begin
            dout = synced_s;
        end else begin
            dout = filt_r;
        end
    end

    // Synchronizer chain; reset clears it so the input reads as inactive-low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
        end
    end

    // Stable-count filter: cnt_r holds the number of earlier differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r <= 1'b0;
            cnt_r  <= '0;
        end else if (!diff_s) begin
            cnt_r <= '0;
        end else if (int'(cnt_r) + 1 >= th_s) begin
            filt_r <= synced_s;
            cnt_r  <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fpga_reset_request.sv
// Reset-request aggregator: merges POR, PLL lock loss, the board pin and
// software requests into one glitch-free, width-guaranteed active-low request.
module fpga_reset_request
    import fpga_reset_request_pkg::*;
#(
    parameter int SYNC_STAGES        = 3,
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES = 64,
    parameter int MIN_ASSERT_CYCLES  = 32,
    parameter int RELEASE_DELAY      = 8,
    parameter int CNT_W              = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             ext_rst_n,
    input  logic             sw_rst_req,
    input  logic             cause_clr,
    output logic             rst_req_n,
    output logic             in_reset,
    output logic [3:0]       rst_cause,
    output logic [CNT_W-1:0] rst_count
);

    localparam int ACNT_W = $clog2(MIN_ASSERT_CYCLES + 1);
    localparam int RCNT_W = $clog2(RELEASE_DELAY + 1);

    state_t            state_r;
    logic [ACNT_W-1:0] acnt_r;
    logic [RCNT_W-1:0] rcnt_r;
    logic              rst_req_n_r;
    logic              in_reset_r;
    logic [3:0]        cause_r;
    logic [CNT_W-1:0]  count_r;
    logic              por_phase_r;
    logic              lock_ok_s;
    logic              ext_filt_s;
    logic              ext_active_s;
    logic              req_s;
    logic [3:0]        cause_set_s;

    fpga_sync_filter #(
        .STAGES      (SYNC_STAGES),
        .RISE_CYCLES (DEBOUNCE_CYCLES),
        .FALL_CYCLES (DEBOUNCE_CYCLES)
    ) u_ext_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ext_rst_n),
        .dout  (ext_filt_s)
    );

    fpga_sync_filter #(
        .STAGES      (SYNC_STAGES),
        .RISE_CYCLES (LOCK_STABLE_CYCLES),
        .FALL_CYCLES (0)
    ) u_lock_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pll_locked),
        .dout  (lock_ok_s)
    );

    assign ext_active_s = ~ext_filt_s;
    assign req_s        = sw_rst_req | ext_active_s | ~lock_ok_s;

    // Cause terms; until the first RUN, missing lock and the pin still being
    // debounced are consequences of power-up and stay attributed to POR.
    always_comb begin
        cause_set_s            = 4'b0000;
        cause_set_s[CAUSE_SW]  = sw_rst_req;
        cause_set_s[CAUSE_EXT] = ext_active_s & ~por_phase_r;
        cause_set_s[CAUSE_PLL] = ~lock_ok_s & ~por_phase_r;
    end

    // Reset sequencing FSM with registered request/in_reset outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_ASSERT;
            acnt_r      <= '0;
            rcnt_r      <= '0;
            rst_req_n_r <= 1'b0;
            in_reset_r  <= 1'b1;
            count_r     <= '0;
            por_phase_r <= 1'b1;
        end else begin
            case (state_r)
                ST_ASSERT: begin
                    if (int'(acnt_r) + 1 >= MIN_ASSERT_CYCLES) begin
                        state_r <= req_s ? ST_WAIT : ST_RELEASE;
                        rcnt_r  <= '0;
                    end else begin
                        acnt_r <= acnt_r + ACNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (!req_s) begin
                        state_r <= ST_RELEASE;
                        rcnt_r  <= '0;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RELEASE: begin
                    if (req_s) begin
                        state_r <= ST_ASSERT;
                        acnt_r  <= '0;
                    end else if (int'(rcnt_r) + 1 >= RELEASE_DELAY) begin
                        state_r     <= ST_RUN;
                        rst_req_n_r <= 1'b1;
                        in_reset_r  <= 1'b0;
                        por_phase_r <= 1'b0;
                    end else begin
                        rcnt_r <= rcnt_r + RCNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (req_s) begin
                        state_r     <= ST_ASSERT;
                        acnt_r      <= '0;
                        rst_req_n_r <= 1'b0;
                        in_reset_r  <= 1'b1;
                        if (count_r != '1) begin
                            count_r <= count_r + CNT_W'(1);
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r     <= ST_ASSERT;
                    acnt_r      <= '0;
                    rst_req_n_r <= 1'b0;
                    in_reset_r  <= 1'b1;
                end
            endcase
        end
    end

    // Sticky cause register; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_r            <= 4'b0000;
            cause_r[CAUSE_POR] <= 1'b1;
        end else begin
            cause_r <= (cause_clr ? 4'b0000 : cause_r) | cause_set_s;
        end
    end

    assign rst_req_n = rst_req_n_r;
    assign in_reset  = in_reset_r;
    assign rst_cause = cause_r;
    assign rst_count = count_r;

endmodule

// File: tb/tb_fpga_reset_request.sv
// Directed bench for fpga_reset_request: POR, software, PLL, pin, release
// interruption, cause clear, counter saturation and asynchronous reset.
module tb_fpga_reset_request;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       ext_rst_n;
    logic       sw_rst_req;
    logic       cause_clr;
    logic       rst_req_n;
    logic       in_reset;
    logic [3:0] rst_cause;
    logic [7:0] rst_count;

    int n_cmp;
    int n_err;
    int n_edges;
    logic low_seen;

    fpga_reset_request dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .ext_rst_n  (ext_rst_n),
        .sw_rst_req (sw_rst_req),
        .cause_clr  (cause_clr),
        .rst_req_n  (rst_req_n),
        .in_reset   (in_reset),
        .rst_cause  (rst_cause),
        .rst_count  (rst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until rst_req_n reads high, bounded by limit.
    task automatic wait_high(output int n, input int limit);
        n = 0;
        do begin
            step();
            n++;
        end while (rst_req_n !== 1'b1 && n < limit);
    endtask

    task automatic pulse_sw();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        ext_rst_n  = 1'b1;
        sw_rst_req = 1'b0;
        cause_clr  = 1'b0;
        repeat (3) step();
        check_eq("por_req_n", rst_req_n, 0);
        check_eq("por_in_reset", in_reset, 1);
        check_eq("por_cause", rst_cause, 4'b0001);
        check_eq("por_count", rst_count, 0);

        rst_n = 1'b1;
        wait_high(n_edges, 200);
        check_eq("por_release_edges", n_edges, 76);
        check_eq("por_in_reset_low", in_reset, 0);
        check_eq("por_cause_after", rst_cause, 4'b0001);
        check_eq("por_count_after", rst_count, 0);

        // one-cycle software request
        pulse_sw();
        check_eq("sw_req_low", rst_req_n, 0);
        check_eq("sw_in_reset", in_reset, 1);
        wait_high(n_edges, 200);
        check_eq("sw_low_width", n_edges, 40);
        check_eq("sw_cause", rst_cause, 4'b1001);
        check_eq("sw_count", rst_count, 1);

        // one-cycle PLL lock loss
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        step();
        check_eq("pll_before_latency", rst_req_n, 1);
        step();
        check_eq("pll_latency", rst_req_n, 0);
        wait_high(n_edges, 200);
        check_eq("pll_low_width", n_edges, 73);
        check_eq("pll_cause", rst_cause, 4'b1011);
        check_eq("pll_count", rst_count, 2);

        // pin glitch shorter than the debounce window
        ext_rst_n = 1'b0;
        repeat (10) step();
        ext_rst_n = 1'b1;
        low_seen  = 1'b0;
        repeat (40) begin
            step();
            if (rst_req_n !== 1'b1) low_seen = 1'b1;
        end
        check_eq("ext_glitch_ignored", low_seen, 0);
        check_eq("ext_glitch_count", rst_count, 2);

        // pin held low exactly the debounce window
        ext_rst_n = 1'b0;
        repeat (16) step();
        ext_rst_n = 1'b1;
        repeat (3) step();
        check_eq("ext_before_latency", rst_req_n, 1);
        step();
        check_eq("ext_latency", rst_req_n, 0);
        wait_high(n_edges, 200);
        check_eq("ext_low_width", n_edges, 40);
        check_eq("ext_cause", rst_cause, 4'b1111);
        check_eq("ext_count", rst_count, 3);

        // pin held low 100 cycles: waits for debounced release
        ext_rst_n = 1'b0;
        repeat (100) step();
        check_eq("ext_hold_low", rst_req_n, 0);
        check_eq("ext_hold_in_reset", in_reset, 1);
        ext_rst_n = 1'b1;
        wait_high(n_edges, 200);
        check_eq("ext_hold_release", n_edges, 28);
        check_eq("ext_hold_count", rst_count, 4);

        // software request during the release window restarts the assertion
        pulse_sw();
        repeat (34) step();
        check_eq("rel_still_low", rst_req_n, 0);
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        check_eq("rel_reassert_low", rst_req_n, 0);
        check_eq("rel_count_same", rst_count, 5);
        wait_high(n_edges, 200);
        check_eq("rel_low_width", n_edges, 40);
        check_eq("rel_count_after", rst_count, 5);

        // clear and software set in the same cycle
        sw_rst_req = 1'b1;
        cause_clr  = 1'b1;
        step();
        sw_rst_req = 1'b0;
        cause_clr  = 1'b0;
        check_eq("clr_set_cause", rst_cause, 4'b1000);
        wait_high(n_edges, 200);
        check_eq("clr_set_width", n_edges, 40);
        check_eq("clr_set_count", rst_count, 6);

        // counter saturation
        for (int i = 0; i < 300; i++) begin
            pulse_sw();
            wait_high(n_edges, 100);
        end
        check_eq("sat_count", rst_count, 255);
        check_eq("sat_last_width", n_edges, 40);

        cause_clr = 1'b1;
        step();
        cause_clr = 1'b0;
        check_eq("clr_only_cause", rst_cause, 4'b0000);

        // asynchronous reset in the middle of the release window
        pulse_sw();
        repeat (34) step();
        check_eq("mid_rel_in_reset", in_reset, 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_req_n", rst_req_n, 0);
        check_eq("async_cause", rst_cause, 4'b0001);
        check_eq("async_count", rst_count, 0);
        check_eq("async_in_reset", in_reset, 1);
        repeat (2) step();
        rst_n = 1'b1;
        wait_high(n_edges, 200);
        check_eq("repor_release_edges", n_edges, 76);
        check_eq("repor_cause", rst_cause, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
